// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, default width,
// and the counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter is clog2(width) wide but never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell shared by the serial datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic Sout,
    output logic Cout
);

    assign Sout = a ^ b ^ cin;
    assign Cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes an operand pair LSB-first,
// one bit per clock, producing {cout, sum} = a + b + cin after WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [RW-1:0]    res_sr, res_shift;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c, last_bit;

    assign last_bit = (cnt == LAST);

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .Sout(fa_s),
        .Cout(fa_c)
    );

    // res_sr only holds the WIDTH-1 bits already produced; the current cell
    // output completes the word, so the final edge can load sum directly.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_nxt   = fa_s;
            assign res_shift = res_sr;
        end else begin : g_wn
            assign res_nxt   = {fa_s, res_sr};
            assign res_shift = res_nxt[WIDTH-1:1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    carry <= cin;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_shift;
                    carry  <= fa_c;
                    // Hold at LAST so the counter never wraps mid-operation.
                    if (!last_bit) cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= res_nxt;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back checks of the 8-bit serial adder.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Returns the number of falling edges until done, or -1 if it never came.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns likewise.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es, input logic ec);
        int lat;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0, lat;
        logic [W:0] exp;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("v1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        chk("v1_done_low", done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum", sum, 8'h7F);
        chk("hold_busy", busy, 0);
        run_op("v2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("v3", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        run_op("v4", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("v5", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("v6", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);

        // Re-pulse start and scramble operands while the add is in flight.
        d0 = done_cnt;
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'hFF;
        wait_done(lat);
        chk("mid_lat", lat, 5);
        chk("mid_sum", sum, 8'h47);
        chk("mid_cout", cout, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_done_cnt", done_cnt - d0, 1);
        chk("mid_busy", busy, 0);

        // Reset in the middle of RUN.
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        run_op("post_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // start held high: accept every 10 cycles, fresh operands each time.
        d0 = done_cnt;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            repeat (8) @(negedge clk);
            chk("b2b_early", done, 0);
            @(negedge clk);
            chk("b2b_done", done, 1);
            chk("b2b_res", {cout, sum}, exp);
            @(posedge clk);
        end
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_done_cnt", done_cnt - d0, 1000);
        chk("b2b_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
